// File: rtl/donkey_sprite_rom.sv
// Donkey sprite texel store: 1-cycle read of {frame, pixel_addr}, vblank-gated write port.
// Define DONKEY_ANIM_EN to enable the vsync-driven frame sequencer; otherwise frame is fixed at 0.
module donkey_sprite_rom #(
  parameter int    FRAMES     = 4,
  parameter int    FRAME_HOLD = 8,
  parameter string INIT_FILE  = "",
  parameter int    FRAME_W    = $clog2(FRAMES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync,
  input  logic                 vblnk,
  input  logic                 moving,
  input  logic [11:0]          pixel_addr,
  output logic [11:0]          rgb_pixel,
  output logic [FRAME_W-1:0]   frame,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FRAME_W+11:0]  wr_addr,
  input  logic [11:0]          wr_data
);

  localparam int DEPTH  = FRAMES * 4096;
  localparam int ADDR_W = FRAME_W + 12;

  logic [11:0] mem [0:DEPTH-1];
  logic        wr_fire;

  function automatic logic frame_in_range(input logic [FRAME_W-1:0] f);
    return ({{(32-FRAME_W){1'b0}}, f} < 32'(FRAMES));
  endfunction

  assign wr_ready = vblnk;
  // Out-of-range frame fields are still handshaken but never reach storage.
  assign wr_fire  = wr_valid && wr_ready && frame_in_range(wr_addr[ADDR_W-1:12]);

  // Storage write port; deliberately independent of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; sees pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_pixel <= 12'h000;
    end else begin
      rgb_pixel <= mem[{frame, pixel_addr}];
    end
  end

`ifdef DONKEY_ANIM_EN
  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  logic              vsync_d;
  logic              tick;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nx;
  logic [FRAME_W-1:0] frame_nx;

  assign tick = vsync && !vsync_d;

  // Next frame/hold values; only a vsync rising edge can change them.
  always_comb begin
    frame_nx    = frame;
    hold_cnt_nx = hold_cnt;
    if (tick && !moving) begin
      frame_nx    = '0;
      hold_cnt_nx = '0;
    end else if (tick && (hold_cnt == HOLD_W'(FRAME_HOLD - 1))) begin
      hold_cnt_nx = '0;
      frame_nx    = (frame == FRAME_W'(FRAMES - 1)) ? '0 : frame + 1'b1;
    end else if (tick) begin
      hold_cnt_nx = hold_cnt + 1'b1;
    end else begin
      frame_nx    = frame;
      hold_cnt_nx = hold_cnt;
    end
  end

  // vsync_d resets high so a vsync held across reset release is not a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d  <= 1'b1;
      frame    <= '0;
      hold_cnt <= '0;
    end else begin
      vsync_d  <= vsync;
      frame    <= frame_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end
`else
  logic unused_anim;

  assign unused_anim = vsync ^ moving;
  assign frame       = '0;
`endif

endmodule

// File: tb/tb_donkey_sprite_rom.sv
// Scoreboard bench for donkey_sprite_rom: reads push expectations, a negedge monitor pops and compares.
// A second FRAMES=3 instance exercises the out-of-range write frame field.
`timescale 1ns/1ps
module tb_donkey_sprite_rom;

  logic        clk = 1'b0;
  logic        rst, vsync, vblnk, moving, wr_valid;
  logic [11:0] pixel_addr, wr_data;
  logic [13:0] wr_addr;
  logic [11:0] rgb_pixel, rgb3;
  logic [1:0]  frame, frame3;
  logic        wr_ready, wr_ready3;

  int n_checks = 0;
  int n_pass   = 0;

  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;

  typedef struct {
    logic [11:0] exp;
    bit          d3;
    string       nm;
  } rd_t;
  rd_t sb[$];

  // texel 0 of each frame, written before the animation run
  logic [11:0] px0 [4]       = '{12'h111, 12'h0F0, 12'h222, 12'h333};
  logic [1:0]  seq_frame [16] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0,
                                  2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
  logic        seq_mov [16]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  donkey_sprite_rom #(.FRAMES(4), .FRAME_HOLD(2)) u_dut (
    .clk(clk), .rst(rst), .vsync(vsync), .vblnk(vblnk), .moving(moving),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel), .frame(frame),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  donkey_sprite_rom #(.FRAMES(3), .FRAME_HOLD(1)) u_dut3 (
    .clk(clk), .rst(rst), .vsync(vsync), .vblnk(vblnk), .moving(moving),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb3), .frame(frame3),
    .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [11:0] addr, input logic [11:0] exp, input bit d3, input string nm);
    rd_t ent;
    ent.exp = exp;
    ent.d3  = d3;
    ent.nm  = nm;
    sb.push_back(ent);
    pixel_addr = addr;
    rd_req     = 1'b1;
    step();
    rd_req     = 1'b0;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [11:0] d);
    wr_valid = 1'b1;
    vblnk    = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    vblnk    = 1'b0;
  endtask

  // track the one-cycle read latency on the bench side
  always @(posedge clk) rd_req_d <= rd_req;

  // monitor: pop and compare whenever a read result is due
  always @(negedge clk) begin
    if (rd_req_d) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 12'h001, 12'h000);
      end else begin
        rd_t e;
        e = sb.pop_front();
        check(e.nm, e.d3 ? rgb3 : rgb_pixel, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] ef;
    rst = 1'b1; vsync = 1'b1; vblnk = 1'b0; moving = 1'b1;
    wr_valid = 1'b0; wr_addr = 14'h0000; wr_data = 12'h000; pixel_addr = 12'h000;

    repeat (3) begin
      @(negedge clk);
      check("rst_rgb", rgb_pixel, 12'h000);
      check("rst_frame", 12'(frame), 12'h000);
    end

    // write issued during reset must still commit
    @(posedge clk); #1;
    wr_valid = 1'b1; vblnk = 1'b1; wr_addr = 14'h0041; wr_data = 12'hABC;
    @(negedge clk);
    check("ready_in_rst", 12'(wr_ready), 12'h001);
    check("rgb_in_rst", rgb_pixel, 12'h000);
    @(posedge clk); #1;
    wr_valid = 1'b0; vblnk = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("ready_low", 12'(wr_ready), 12'h000);

    issue_read(12'h041, 12'hABC, 1'b0, "rd_latency");
    repeat (3) step();
    check("no_tick_rel", 12'(frame), 12'h000);

    do_write(14'h0000, 12'h111);
    do_write({2'd2, 12'h000}, 12'h222);
    do_write({2'd3, 12'h000}, 12'h333);
    do_write(14'h0002, 12'h444);
    do_write(14'h0123, 12'h456);

    // held request outside vblank must not write
    wr_valid = 1'b1; wr_addr = 14'h0002; wr_data = 12'h777;
    @(negedge clk);
    check("gate_ready_lo", 12'(wr_ready), 12'h000);
    step(); step();
    wr_valid = 1'b0;
    issue_read(12'h002, 12'h444, 1'b0, "gate_nowrite");

    wr_valid = 1'b1; wr_addr = {2'd1, 12'h000}; wr_data = 12'h0F0;
    step();
    @(negedge clk);
    check("gate_hold_lo", 12'(wr_ready), 12'h000);
    @(posedge clk); #1;
    vblnk = 1'b1;
    @(negedge clk);
    check("gate_ready_hi", 12'(wr_ready), 12'h001);
    @(posedge clk); #1;
    wr_valid = 1'b0; vblnk = 1'b0;

    // read-first collision
    wr_valid = 1'b1; vblnk = 1'b1; wr_addr = 14'h0123; wr_data = 12'h789;
    issue_read(12'h123, 12'h456, 1'b0, "collide_old");
    wr_valid = 1'b0; vblnk = 1'b0;
    issue_read(12'h123, 12'h789, 1'b0, "collide_new");

    // frame field 3 is out of range for the FRAMES=3 instance
    wr_valid = 1'b1; vblnk = 1'b1; wr_addr = {2'd3, 12'h123}; wr_data = 12'hBAD;
    @(negedge clk);
    check("oor_ready", 12'(wr_ready3), 12'h001);
    @(posedge clk); #1;
    wr_valid = 1'b0; vblnk = 1'b0;
    issue_read(12'h123, 12'h789, 1'b1, "oor_unchanged");

    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        moving = 1'b0;
        step();
      end
      moving = seq_mov[i];
      vsync = 1'b0;
      step();
      vsync = 1'b1;
      step();
`ifdef DONKEY_ANIM_EN
      ef = seq_frame[i];
`else
      ef = 2'd0;
`endif
      issue_read(12'h000, px0[ef], 1'b0, "anim_px");
      check("anim_frame", 12'(frame), 12'(ef));
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_frame", 12'(frame), 12'h000);
    check("mid_rst_rgb", rgb_pixel, 12'h000);
    issue_read(12'h000, 12'h111, 1'b0, "post_rst_px");

    repeat (3) step();
    check("sb_drain", 12'(sb.size()), 12'h000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
